pc_target_unit: RTL and testbench
=================================

// Module: pc_target_unit
// PURPOSE
//   Program-counter register and next-PC generator for the 16-bit single-cycle core.
//   It generalises the jump-immediate sign extender:
//   - parametrised widths for the jump and branch immediates;
//   - optional word-offset shift;
//   - PC-relative target adders;
//   - register-indirect jump;
//   - stall and halt control;
//   - redirect and wrap status flags.
//   It sits between the decoder/ALU flags and instruction-memory address input.
// PARAMETERS
//   DATA_W    16      PC / datapath width
//   JIMM_W    12      jump immediate width (signed), JIMM_W < DATA_W
//   BIMM_W    8       branch immediate width (signed), BIMM_W < DATA_W
//   SHIFT     0       left shift applied to extended offsets (0..2)
//   PC_INC    1       sequential increment
//   RESET_PC  0       PC value loaded on reset (DATA_W bits)
// PORTS
//   clk          in   1        rising-edge clock
//   rst_n        in   1        synchronous reset, active-low
//   stall        in   1        hold PC this cycle
//   halt         in   1        enter HALT state
//   jump         in   1        PC-relative jump using imm_j
//   jr           in   1        register-indirect jump to reg_target
//   branch       in   1        conditional branch instruction
//   taken        in   1        branch condition result (qualifies branch)
//   imm_j        in   JIMM_W   jump offset, two's complement
//   imm_b        in   BIMM_W   branch offset, two's complement
//   reg_target   in   DATA_W   absolute target for jr
//   pc           out  DATA_W   current PC (registered)
//   pc_seq       out  DATA_W   pc + PC_INC, combinational, mod 2^DATA_W
//   j_ext        out  DATA_W   sign-extended, shifted imm_j, combinational
//   redirect     out  1        registered; 1 for one cycle after a non-sequential PC load
//   wrap         out  1        registered; 1 for one cycle after a PC update whose exact result left [0, 2^DATA_W-1]
//   halted       out  1        1 while in HALT
// BEHAVIOUR
//   Reset: when rst_n=0 at a clk edge:
//   - pc=RESET_PC, redirect=0, wrap=0, halted=0, state=RUN;
//   - this overrides all other inputs, including in HALT.
//   Extension: ext(x,W) = {{(DATA_W-W){x[W-1]}}, x} << SHIFT; shifted-out bits are discarded.
//   j_ext = ext(imm_j,JIMM_W).
//   Target arithmetic: computed in DATA_W+2 signed bits.
//   - base = pc + PC_INC;
//   - jump target = base + ext(imm_j); branch target = base + ext(imm_b);
//   - result truncated to DATA_W; wrap source = exact result <0 or >2^DATA_W-1.
//   - sequential increment past max also wraps to 0 and sets wrap.
//   States: RUN, HALT.
//   - RUN --halt--> HALT; HALT exits only via reset.
//   RUN priority per cycle, highest first:
//   - halt: pc holds, next state HALT, redirect=0, wrap=0;
//   - stall: pc holds, redirect=0, wrap=0;
//   - jr: pc=reg_target, redirect=1, wrap=0;
//   - jump: pc=jump target, redirect=1;
//   - branch&taken: pc=branch target, redirect=1;
//   - otherwise: pc=pc_seq, redirect=0.
//   - branch with taken=0 is sequential; taken without branch is ignored.
//   HALT: pc, flags and halted hold regardless of stall/jump/jr/branch; redirect=0, wrap=0.
//   Latency: new pc visible one clk after the deciding edge inputs. redirect and wrap align with that new pc.
//   Simultaneous jump+jr+branch is resolved only by priority; no error flag.
// TESTING (DATA_W=16, JIMM_W=12, BIMM_W=8, SHIFT=0, PC_INC=1, RESET_PC=0)
//   1. Reset: rst_n=0 for 2 cycles with jump=1 -> pc=0x0000, redirect=0, wrap=0, halted=0.
//   2. Jump: pc=0x0010, jump=1, imm_j=0x05A -> j_ext=0x005A, next pc=0x006B, redirect=1 for exactly 1 cycle.
//   3. Negative jump: pc=0x0010, imm_j=0x800 -> j_ext=0xF800, next pc=0xF811, wrap=1.
//      Sequential run from pc=0xFFFF -> pc=0x0000, wrap=1.
//   4. Branch: pc=0x0020, branch=1, imm_b=0xFF.
//      taken=1 -> pc=0x0020, redirect=1; taken=0 -> pc=0x0021, redirect=0.
//   5. Priority: jr=1, jump=1, reg_target=0xBEEF -> pc=0xBEEF.
//      stall=1 with jr=1 -> pc unchanged, redirect=0.
//   6. Halt: halt=1 at pc=0x0040 -> halted=1, pc stays 0x0040 across jump/jr.
//      rst_n=0 mid-halt -> pc=0x0000, halted=0.

Source files
------------

// File: rtl/pc_target_if.sv
// Purpose : groups the control, immediate and status signals of pc_target_unit
//           into one bundle.
// Signals : stall, halt, jump, jr, branch, taken -- control inputs to the unit
//           imm_j [JIMM_W], imm_b [BIMM_W]       -- two's complement offsets
//           reg_target [DATA_W]                  -- absolute jr target
//           pc, pc_seq, j_ext [DATA_W]           -- PC and derived values
//           redirect, wrap, halted               -- status flags
// Modports: master drives the controls and reads the results.
//           slave is the pc_target_unit side.
// The unit has no valid/ready handshake. Every control input is sampled on
// every rising clk edge. Inputs must be stable around that edge.
interface pc_target_if #(
    parameter int DATA_W = 16,
    parameter int JIMM_W = 12,
    parameter int BIMM_W = 8
);
    logic              stall;
    logic              halt;
    logic              jump;
    logic              jr;
    logic              branch;
    logic              taken;
    logic [JIMM_W-1:0] imm_j;
    logic [BIMM_W-1:0] imm_b;
    logic [DATA_W-1:0] reg_target;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_seq;
    logic [DATA_W-1:0] j_ext;
    logic              redirect;
    logic              wrap;
    logic              halted;

    modport master (
        output stall, halt, jump, jr, branch, taken, imm_j, imm_b, reg_target,
        input  pc, pc_seq, j_ext, redirect, wrap, halted
    );

    modport slave (
        input  stall, halt, jump, jr, branch, taken, imm_j, imm_b, reg_target,
        output pc, pc_seq, j_ext, redirect, wrap, halted
    );
endinterface

// File: rtl/pc_target_unit.sv
// Purpose : program-counter register and next-PC generator for the 16-bit
//           single-cycle core. It supports:
//             - sequential increment;
//             - PC-relative jump and branch;
//             - register-indirect jump;
//             - stall;
//             - a sticky HALT state that only reset leaves.
// Ports   : clk        rising-edge clock
//           rst_n      synchronous reset, active-low
//           bus        pc_target_if.slave (controls in, pc/status out)
//           dbg_state  current FSM state (0 = RUN, 1 = HALT)
module pc_target_unit #(
    parameter int                DATA_W   = 16,
    parameter int                JIMM_W   = 12,
    parameter int                BIMM_W   = 8,
    parameter int                SHIFT    = 0,
    parameter int                PC_INC   = 1,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_target_if.slave     bus,
    output logic           dbg_state
);
    // Targets are formed in two extra bits. The top two bits of a sum then
    // tell whether the exact result fell below 0 or rose above 2^DATA_W-1.
    localparam int              XW    = DATA_W + 2;
    localparam logic [XW-1:0]   INC_X = XW'(PC_INC);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              redirect_q, redirect_d;
    logic              wrap_q, wrap_d;

    logic [DATA_W-1:0] j_ext, b_ext;
    logic [XW-1:0]     base_x, j_sum, b_sum;
    logic              seq_wrap, j_wrap, b_wrap;

    // Sign-extend to DATA_W first, then shift. Bits shifted past DATA_W are lost.
    assign j_ext = {{(DATA_W-JIMM_W){bus.imm_j[JIMM_W-1]}}, bus.imm_j} << SHIFT;
    assign b_ext = {{(DATA_W-BIMM_W){bus.imm_b[BIMM_W-1]}}, bus.imm_b} << SHIFT;

    assign base_x = {2'b00, pc_q} + INC_X;
    assign j_sum  = base_x + {{2{j_ext[DATA_W-1]}}, j_ext};
    assign b_sum  = base_x + {{2{b_ext[DATA_W-1]}}, b_ext};

    // Bit XW-1 set means the result is negative.
    // Bit XW-2 set on a non-negative result means it is at or above 2^DATA_W.
    assign seq_wrap = base_x[XW-2];
    assign j_wrap   = j_sum[XW-1] | j_sum[XW-2];
    assign b_wrap   = b_sum[XW-1] | b_sum[XW-2];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        wrap_d     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.jr) begin
                    pc_d       = bus.reg_target;
                    redirect_d = 1'b1;
                end else if (bus.jump) begin
                    pc_d       = j_sum[DATA_W-1:0];
                    redirect_d = 1'b1;
                    wrap_d     = j_wrap;
                end else if (bus.branch && bus.taken) begin
                    pc_d       = b_sum[DATA_W-1:0];
                    redirect_d = 1'b1;
                    wrap_d     = b_wrap;
                end else begin
                    pc_d   = base_x[DATA_W-1:0];
                    wrap_d = seq_wrap;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_seq   = base_x[DATA_W-1:0];
    assign bus.j_ext    = j_ext;
    assign bus.redirect = redirect_q;
    assign bus.wrap     = wrap_q;
    assign bus.halted   = (state_q == ST_HALT);
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_pc_target_unit.sv
module tb_pc_target_unit;
    localparam int DATA_W = 16;
    localparam int JIMM_W = 12;
    localparam int BIMM_W = 8;

    logic clk;
    logic rst_n;
    logic dbg_state;

    pc_target_if #(.DATA_W(DATA_W), .JIMM_W(JIMM_W), .BIMM_W(BIMM_W)) bus ();

    pc_target_unit #(
        .DATA_W(DATA_W), .JIMM_W(JIMM_W), .BIMM_W(BIMM_W),
        .SHIFT(0), .PC_INC(1), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    // Expected vector layout: {pc[15:0], redirect, wrap, halted}
    logic [18:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_pc     = 0;
    bit          m_halt   = 1'b0;

    function automatic int sext(int v, int w);
        int m;
        m = v & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) return m - (1 << w);
        return m;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_in();
        bus.stall      = 1'b0;
        bus.halt       = 1'b0;
        bus.jump       = 1'b0;
        bus.jr         = 1'b0;
        bus.branch     = 1'b0;
        bus.taken      = 1'b0;
        bus.imm_j      = '0;
        bus.imm_b      = '0;
        bus.reg_target = '0;
    endtask

    // Predicts the result of the coming edge from the driven inputs.
    // Pushes it to the scoreboard, clocks once, then pops and compares.
    task automatic cycle(string tag);
        int          exact;
        logic [15:0] npc;
        logic        nred;
        logic        nwrap;
        bit          nhalt;
        logic [18:0] e;
        npc   = m_pc[15:0];
        nred  = 1'b0;
        nwrap = 1'b0;
        nhalt = m_halt;
        if (!rst_n) begin
            npc   = 16'h0000;
            nhalt = 1'b0;
        end else if (m_halt) begin
            nhalt = 1'b1;
        end else if (bus.halt) begin
            nhalt = 1'b1;
        end else if (bus.stall) begin
            nred = 1'b0;
        end else if (bus.jr) begin
            npc  = bus.reg_target;
            nred = 1'b1;
        end else if (bus.jump) begin
            exact = m_pc + 1 + sext(int'(bus.imm_j), JIMM_W);
            npc   = exact[15:0];
            nred  = 1'b1;
            nwrap = (exact < 0) || (exact > 65535);
        end else if (bus.branch && bus.taken) begin
            exact = m_pc + 1 + sext(int'(bus.imm_b), BIMM_W);
            npc   = exact[15:0];
            nred  = 1'b1;
            nwrap = (exact < 0) || (exact > 65535);
        end else begin
            exact = m_pc + 1;
            npc   = exact[15:0];
            nwrap = (exact > 65535);
        end
        exp_q.push_back({npc, nred, nwrap, nhalt});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ":pc"},       32'(bus.pc),       32'(e[18:3]));
        check({tag, ":redirect"}, 32'(bus.redirect), 32'(e[2]));
        check({tag, ":wrap"},     32'(bus.wrap),     32'(e[1]));
        check({tag, ":halted"},   32'(bus.halted),   32'(e[0]));
        check({tag, ":state"},    32'(dbg_state),    32'(e[0]));
        m_pc   = int'(npc);
        m_halt = nhalt;
    endtask

    task automatic load_pc(logic [15:0] v);
        clear_in();
        bus.jr         = 1'b1;
        bus.reg_target = v;
        cycle("load");
        clear_in();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        clear_in();
        @(posedge clk);
        #1;

        // 1. Reset dominates a pending jump
        bus.jump  = 1'b1;
        bus.imm_j = 12'h123;
        cycle("rst0");
        cycle("rst1");
        check("reset_pc", 32'(bus.pc), 32'h0000);
        check("reset_redirect", 32'(bus.redirect), 32'h0);
        rst_n = 1'b1;
        clear_in();

        // 2. Positive jump, redirect lasts exactly one cycle
        load_pc(16'h0010);
        bus.jump  = 1'b1;
        bus.imm_j = 12'h05A;
        #1;
        check("jump_j_ext", 32'(bus.j_ext), 32'h005A);
        check("jump_pc_seq", 32'(bus.pc_seq), 32'h0011);
        cycle("jump");
        check("jump_pc_const", 32'(bus.pc), 32'h006B);
        clear_in();
        cycle("jump_after");
        check("jump_redirect_drop", 32'(bus.redirect), 32'h0);

        // 3. Negative jump below zero, then sequential wrap at 0xFFFF
        load_pc(16'h0010);
        bus.jump  = 1'b1;
        bus.imm_j = 12'h800;
        #1;
        check("neg_j_ext", 32'(bus.j_ext), 32'hF800);
        cycle("negjump");
        check("neg_pc_const", 32'(bus.pc), 32'hF811);
        check("neg_wrap_const", 32'(bus.wrap), 32'h1);
        load_pc(16'hFFFF);
        cycle("seq_wrap");
        check("seq_wrap_pc", 32'(bus.pc), 32'h0000);
        check("seq_wrap_flag", 32'(bus.wrap), 32'h1);
        cycle("seq_after");

        // Positive overflow on a jump
        load_pc(16'hFFF0);
        bus.jump  = 1'b1;
        bus.imm_j = 12'h7FF;
        cycle("jump_ovf");

        // 4. Branch taken / not taken; taken without branch is ignored
        load_pc(16'h0020);
        bus.branch = 1'b1;
        bus.imm_b  = 8'hFF;
        bus.taken  = 1'b1;
        cycle("br_taken");
        check("br_taken_pc", 32'(bus.pc), 32'h0020);
        bus.taken = 1'b0;
        cycle("br_not_taken");
        check("br_nt_pc", 32'(bus.pc), 32'h0021);
        bus.branch = 1'b0;
        bus.taken  = 1'b1;
        cycle("taken_only");
        clear_in();

        // 5. Priority: jr over jump, stall over jr
        bus.jr         = 1'b1;
        bus.jump       = 1'b1;
        bus.branch     = 1'b1;
        bus.taken      = 1'b1;
        bus.reg_target = 16'hBEEF;
        bus.imm_j      = 12'h00F;
        cycle("prio_jr");
        check("prio_pc", 32'(bus.pc), 32'hBEEF);
        bus.stall      = 1'b1;
        bus.reg_target = 16'h1234;
        cycle("prio_stall");
        check("stall_pc", 32'(bus.pc), 32'hBEEF);
        clear_in();

        // Random mixes of the RUN-state controls
        for (int i = 0; i < 40; i++) begin
            bus.stall      = ($urandom_range(0, 5) == 0);
            bus.jr         = ($urandom_range(0, 4) == 0);
            bus.jump       = ($urandom_range(0, 2) == 0);
            bus.branch     = $urandom_range(0, 1);
            bus.taken      = $urandom_range(0, 1);
            bus.imm_j      = 12'($urandom_range(0, 4095));
            bus.imm_b      = 8'($urandom_range(0, 255));
            bus.reg_target = 16'($urandom_range(0, 65535));
            cycle("rand");
        end
        clear_in();

        // 6. Halt is sticky until reset
        load_pc(16'h0040);
        bus.halt = 1'b1;
        cycle("halt");
        check("halt_flag", 32'(bus.halted), 32'h1);
        clear_in();
        bus.jump  = 1'b1;
        bus.imm_j = 12'h010;
        cycle("halt_jump");
        bus.jump       = 1'b0;
        bus.jr         = 1'b1;
        bus.reg_target = 16'h5555;
        cycle("halt_jr");
        check("halt_pc_hold", 32'(bus.pc), 32'h0040);
        rst_n = 1'b0;
        cycle("halt_reset");
        check("halt_reset_pc", 32'(bus.pc), 32'h0000);
        check("halt_reset_flag", 32'(bus.halted), 32'h0);
        rst_n = 1'b1;
        clear_in();
        cycle("post_reset_seq");

        // Every pushed expectation must have been popped
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
